hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline, covering the hazards that operand forwarding cannot resolve.
- Inspects the instruction in ID against the destinations in ID/EX and EX/MEM, and tracks the multi-cycle mult/div unit.
- Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- Sits in ID, beside the control unit.

Parameters:
- MDU_LATENCY, 32, cycles the mult/div unit is busy after a start pulse (range 1..63).
- CNT_W, 6, width of the MDU busy counter.

Ports:
- Clock  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ID_Instruction  in  32  instruction currently in ID.
- IDEX_MemRead  in  1  ID/EX instruction is a load.
- IDEX_RegWrite  in  1  ID/EX instruction writes a register.
- IDEX_WriteReg  in  5  ID/EX destination register.
- EXMEM_MemRead  in  1  EX/MEM instruction is a load.
- EXMEM_WriteReg  in  5  EX/MEM destination register.
- EX_MulDivStart  in  1  one-cycle pulse; mult/div issued from EX.
- BranchTaken  in  1  branch/jump in ID resolved taken.
- PCWriteEn  out  1  PC update enable.
- IFIDWriteEn  out  1  IF/ID register write enable.
- IDEXBubble  out  1  zero the control fields entering ID/EX.
- IFIDFlush  out  1  replace the IF/ID instruction with a nop.
- MduBusy  out  1  mult/div unit busy.
- Stall  out  1  OR of all stall causes.

Behaviour:
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
- rs is a source unless op is 000010 or 000011 (j/jal).
- rt is a source if any of:
  - op=000000 (R-type);
  - op=000100 or 000101 (beq/bne);
  - op is 101011, 101001 or 101000 (sw/sh/sb).
- Register 0 never causes a hazard.
- Load-use hazard: IDEX_MemRead and IDEX_WriteReg equals a used source.
- Branch hazard (op beq/bne only), any of:
  - IDEX_RegWrite and IDEX_WriteReg matches a source;
  - EXMEM_MemRead and EXMEM_WriteReg matches a source.
- A load followed by a dependent branch therefore stalls 2 cycles: the first via ID/EX, the second via EX/MEM.
- MDU hazard: state MDU_BUSY and ID instruction is op=0 with funct in {010000, 010010, 011000..011011} (mfhi, mflo, mult, multu, div, divu).
- Stall = load-use | branch | MDU hazard. Combinational; same-cycle response.
- PCWriteEn = IFIDWriteEn = ~Stall.
- IDEXBubble = Stall.
- IFIDFlush = BranchTaken & ~Stall. When a stall and a taken branch coincide, the stall wins; the branch re-resolves once the stall clears.
- MDU state machine:
  - States: RUN, MDU_BUSY.
  - RUN: on EX_MulDivStart, load counter=MDU_LATENCY and go to MDU_BUSY.
  - MDU_BUSY: decrement counter each cycle; on the edge where counter==1, go to RUN with counter=0.
  - EX_MulDivStart while in MDU_BUSY is ignored; it cannot legally occur, since dependents are stalled.
  - MduBusy = (state==MDU_BUSY).
  - With MDU_LATENCY=1: busy for exactly 1 cycle after the start edge.
- Reset (async, Reset=0): state=RUN, counter=0, MduBusy=0.
  - All combinational outputs then depend only on the load/branch terms: with all inputs 0, PCWriteEn=1, IFIDWriteEn=1, IDEXBubble=0, IFIDFlush=0, Stall=0.
  - Reset asserted mid-busy aborts the MDU wait immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output StallCycles [31:0].
  - Increments on every rising edge where Stall=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by Reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- ID/EX holds lw $8 (IDEX_MemRead=1, WriteReg=8); ID holds add $9,$8,$10 (0x010A4820) -> Stall=1, PCWriteEn=0, IDEXBubble=1 for 1 cycle. Next cycle (load moved to EX/MEM, IDEX_MemRead=0) -> Stall=0.
- lw $4 in ID/EX, beq $4,$0 in ID -> Stall for 2 consecutive cycles (ID/EX match, then EXMEM_MemRead match); IFIDFlush=0 throughout, even with BranchTaken=1. Third cycle, BranchTaken=1 -> IFIDFlush=1, Stall=0.
- ID holds add $9,$0,$0 with IDEX_MemRead=1, WriteReg=0 -> Stall=0 (no hazard on register 0).
- MDU_LATENCY=4: pulse EX_MulDivStart, with ID holding mflo (funct 010010) -> MduBusy=1 and Stall=1 for exactly 4 cycles, then Stall=0. An unrelated add in ID during busy -> Stall=0.
- Mid-MDU_BUSY, drive Reset=0 asynchronously between clock edges -> MduBusy drops to 0 immediately, Stall=0 with mflo in ID; after release, normal operation resumes.
- With HAZARD_PERF_CNT_EN defined: run the first and fourth scenarios back-to-back -> StallCycles=5.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard stall unit: ID/EX/MEM hazard inputs and stall/flush controls.
// HAZARD_PERF_CNT_EN adds the stall_cycles performance counter output.
interface hazard_stall_unit_if;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  logic [INSTR_W-1:0] id_instruction;
  logic               idex_mem_read;
  logic               idex_reg_write;
  logic [REG_W-1:0]   idex_write_reg;
  logic               exmem_mem_read;
  logic [REG_W-1:0]   exmem_write_reg;
  logic               ex_mul_div_start;
  logic               branch_taken;

  logic               pc_write_en_c;
  logic               ifid_write_en_c;
  logic               idex_bubble_c;
  logic               ifid_flush_c;
  logic               mdu_busy;
  logic               stall_c;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]        stall_cycles;
`endif

  modport master (
    output id_instruction, idex_mem_read, idex_reg_write, idex_write_reg,
           exmem_mem_read, exmem_write_reg, ex_mul_div_start, branch_taken,
    input  pc_write_en_c, ifid_write_en_c, idex_bubble_c, ifid_flush_c,
           mdu_busy, stall_c
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  id_instruction, idex_mem_read, idex_reg_write, idex_write_reg,
           exmem_mem_read, exmem_write_reg, ex_mul_div_start, branch_taken,
    output pc_write_en_c, ifid_write_en_c, idex_bubble_c, ifid_flush_c,
           mdu_busy, stall_c
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush controller for load-use, branch-operand and mult/div hazards.
// Optional HAZARD_PERF_CNT_EN: saturating count of stalled cycles on bus.stall_cycles.
module hazard_stall_unit #(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input logic              clk,
  input logic              rst_n,
  hazard_stall_unit_if.slave bus
);
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_SH    = 6'b101001;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [OP_W-1:0] FN_MFLO  = 6'b010010;

  typedef enum logic {RUN, MDU_BUSY} mdu_state_e;

  mdu_state_e       state;
  logic [CNT_W-1:0] mdu_cnt;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [OP_W-1:0]  funct;
  logic             is_branch;
  logic             rs_live;
  logic             rt_live;
  logic             idex_match;
  logic             exmem_match;
  logic             load_use_haz;
  logic             branch_haz;
  logic             mdu_op;
  logic             mdu_haz;
  logic             stall;
  logic             unused_instr_bits;

  assign op    = bus.id_instruction[31:26];
  assign rs    = bus.id_instruction[25:21];
  assign rt    = bus.id_instruction[20:16];
  assign funct = bus.id_instruction[5:0];
  assign unused_instr_bits = ^bus.id_instruction[15:6];

  // Source-register usage by opcode class; $0 is never a real dependency.
  always_comb begin
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
    rs_live   = !((op == OP_J) || (op == OP_JAL)) && (rs != '0);
    rt_live   = ((op == OP_RTYPE) || is_branch ||
                 (op == OP_SW) || (op == OP_SH) || (op == OP_SB)) && (rt != '0);
  end

  always_comb begin
    idex_match  = (rs_live && (bus.idex_write_reg == rs)) ||
                  (rt_live && (bus.idex_write_reg == rt));
    exmem_match = (rs_live && (bus.exmem_write_reg == rs)) ||
                  (rt_live && (bus.exmem_write_reg == rt));
  end

  // Branches compare in ID, so they also wait on ALU results and on loads one stage further on.
  always_comb begin
    load_use_haz = bus.idex_mem_read && idex_match;
    branch_haz   = is_branch &&
                   ((bus.idex_reg_write && idex_match) ||
                    (bus.exmem_mem_read && exmem_match));
    mdu_op       = (op == OP_RTYPE) &&
                   ((funct == FN_MFHI) || (funct == FN_MFLO) || (funct[5:2] == 4'b0110));
    mdu_haz      = (state == MDU_BUSY) && mdu_op;
    stall        = load_use_haz || branch_haz || mdu_haz;
  end

  assign bus.stall_c         = stall;
  assign bus.pc_write_en_c   = !stall;
  assign bus.ifid_write_en_c = !stall;
  assign bus.idex_bubble_c   = stall;
  assign bus.ifid_flush_c    = bus.branch_taken && !stall;
  assign bus.mdu_busy        = (state == MDU_BUSY);

  // Mult/div busy tracker; a start while already busy cannot occur and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.ex_mul_div_start) begin
            state   <= MDU_BUSY;
            mdu_cnt <= CNT_W'(MDU_LATENCY);
          end
        end
        MDU_BUSY: begin
          if (mdu_cnt == CNT_W'(1)) begin
            state   <= RUN;
            mdu_cnt <= '0;
          end else begin
            mdu_cnt <= mdu_cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= RUN;
          mdu_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit with MDU_LATENCY=4 and hand-computed directed vectors.
module tb_hazard_stall_unit;
  logic clk;
  logic rst_n;

  hazard_stall_unit_if bus ();

  hazard_stall_unit #(.MDU_LATENCY(4), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        stall;
    logic        flush;
    logic        busy;
    logic        chk_perf;
    logic [31:0] perf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  localparam logic [31:0] I_NOP    = 32'h0000_0000;
  localparam logic [31:0] I_ADD_LU = 32'h010A_4820;
  localparam logic [31:0] I_ADD_Z  = 32'h0000_4820;
  localparam logic [31:0] I_BEQ4   = 32'h1080_0004;
  localparam logic [31:0] I_MFLO   = 32'h0000_1012;
  localparam logic [31:0] I_MFHI   = 32'h0000_1010;
  localparam logic [31:0] I_MULT   = 32'h0085_0018;
  localparam logic [31:0] I_DIVU   = 32'h0085_001B;
  localparam logic [31:0] I_SW     = 32'hACC5_0000;
  localparam logic [31:0] I_ADDI   = 32'h20C5_0001;
  localparam logic [31:0] I_J      = 32'h0900_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] ins, input bit mr, input bit rw, input logic [4:0] wr,
                       input bit xmr, input logic [4:0] xwr, input bit st, input bit bt);
    bus.id_instruction   = ins;
    bus.idex_mem_read    = mr;
    bus.idex_reg_write   = rw;
    bus.idex_write_reg   = wr;
    bus.exmem_mem_read   = xmr;
    bus.exmem_write_reg  = xwr;
    bus.ex_mul_div_start = st;
    bus.branch_taken     = bt;
  endtask

  task automatic push(input int id, input bit s, input bit f, input bit b,
                      input bit cp, input logic [31:0] perf);
    exp_t e;
    e.id = 16'(id); e.stall = s; e.flush = f; e.busy = b; e.chk_perf = cp; e.perf = perf;
    sb_q.push_back(e);
  endtask

  // One cycle of stimulus: inputs change just after the rising edge, expectation queued.
  task automatic step(input int id, input logic [31:0] ins, input bit mr, input bit rw,
                      input logic [4:0] wr, input bit xmr, input logic [4:0] xwr,
                      input bit st, input bit bt, input bit s, input bit f, input bit b);
    @(posedge clk);
    #1;
    drive(ins, mr, rw, wr, xmr, xwr, st, bt);
    push(id, s, f, b, 1'b0, 32'd0);
  endtask

  task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec=%0d %s actual=0x%0h required=0x%0h", id, nm, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each queued cycle is checked mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp(int'(e.id), "stall",       32'(bus.stall_c),         32'(e.stall));
      cmp(int'(e.id), "pc_we",       32'(bus.pc_write_en_c),   32'(!e.stall));
      cmp(int'(e.id), "ifid_we",     32'(bus.ifid_write_en_c), 32'(!e.stall));
      cmp(int'(e.id), "idex_bubble", 32'(bus.idex_bubble_c),   32'(e.stall));
      cmp(int'(e.id), "ifid_flush",  32'(bus.ifid_flush_c),    32'(e.flush));
      cmp(int'(e.id), "mdu_busy",    32'(bus.mdu_busy),        32'(e.busy));
`ifdef HAZARD_PERF_CNT_EN
      if (e.chk_perf) cmp(int'(e.id), "stall_cycles", bus.stall_cycles, e.perf);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(I_NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0);

    // Reset state with all inputs low
    step(1, I_NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    drive(I_ADD_LU, 1, 1, 5'd8, 0, 5'd0, 0, 0);
    push(2, 1, 0, 0, 1'b0, 32'd0);
    step(3, I_ADD_LU, 0, 0, 5'd0, 1, 5'd8, 0, 0, 0, 0, 0);

    // MDU wait: mflo stalls exactly 4 cycles
    step(4, I_NOP, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);
    for (int i = 5; i <= 8; i++) step(i, I_MFLO, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
    @(posedge clk); #1;
    drive(I_MFLO, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    push(9, 0, 0, 0, 1'b1, 32'd5);

    // Load feeding a branch: two stall cycles, flush held off until clear
    step(10, I_BEQ4, 1, 1, 5'd4, 0, 5'd0, 0, 1, 1, 0, 0);
    step(11, I_BEQ4, 0, 0, 5'd0, 1, 5'd4, 0, 1, 1, 0, 0);
    step(12, I_BEQ4, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 0);

    // Operand-class and register-0 boundaries
    step(13, I_ADD_Z,  1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    step(14, I_BEQ4,   0, 1, 5'd4, 0, 5'd0, 0, 0, 1, 0, 0);
    step(15, I_SW,     1, 1, 5'd5, 0, 5'd0, 0, 0, 1, 0, 0);
    step(16, I_ADDI,   1, 1, 5'd5, 0, 5'd0, 0, 0, 0, 0, 0);
    step(17, I_ADDI,   1, 1, 5'd6, 0, 5'd0, 0, 0, 1, 0, 0);
    step(18, I_J,      1, 1, 5'd8, 0, 5'd0, 0, 1, 0, 1, 0);
    step(19, I_ADD_LU, 0, 1, 5'd8, 0, 5'd0, 0, 0, 0, 0, 0);
    step(20, I_ADD_LU, 0, 0, 5'd0, 1, 5'd8, 0, 0, 0, 0, 0);

    // MDU busy: unrelated add passes, mult/mfhi/divu stall
    step(21, I_NOP,    0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);
    step(22, I_ADD_LU, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
    step(23, I_MULT,   0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
    step(24, I_MFHI,   0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
    step(25, I_DIVU,   0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
    step(26, I_MFLO,   0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-busy aborts the wait
    step(27, I_NOP,  0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);
    step(28, I_MFLO, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
    @(posedge clk); #1;
    drive(I_MFLO, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    #1; rst_n = 1'b0;
    push(29, 0, 0, 0, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(I_MFLO, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    push(30, 0, 0, 0, 1'b0, 32'd0);
    step(31, I_ADD_LU, 1, 1, 5'd8, 0, 5'd0, 0, 0, 1, 0, 0);
    step(32, I_NOP,    0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);
    step(33, I_MFLO,   0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
